async_fifo_lvl: RTL and testbench

ASYNC_FIFO_LVL -- requirements
Module: async_fifo_lvl

---
 rtl/async_fifo_lvl.sv | 153 +++++++++++++++
 tb/tb_async_fifo_lvl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/async_fifo_lvl.sv
`default_nettype none
`timescale 1ns/100ps
// ============================================================================
// Module  : async_fifo_lvl
// Brief   : Dual-clock FIFO with Gray-coded pointer sync, fill levels and
//           almost-full / almost-empty / overflow / underflow flags.
// Revision: 1.0 - initial release
// ============================================================================
module async_fifo_lvl #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int AF_LEVEL    = DEPTH - 2,
    parameter int AE_LEVEL    = 2
) (
    input  logic                     wclk,
    input  logic                     wrstn,
    input  logic                     winc,
    input  logic [WIDTH-1:0]         wdata,
    output logic                     wfull,
    output logic                     walmost_full,
    output logic                     woverflow,
    output logic [$clog2(DEPTH):0]   wlevel,
    input  logic                     rclk,
    input  logic                     rrstn,
    input  logic                     rinc,
    output logic [WIDTH-1:0]         rdata,
    output logic                     rempty,
    output logic                     ralmost_empty,
    output logic                     runderflow,
    output logic [$clog2(DEPTH):0]   rlevel
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_af_lvl = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] c_ae_lvl = (AW+1)'(AE_LEVEL);

    function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
        logic [AW:0] b;
        for (int i = 0; i <= AW; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

    logic [WIDTH-1:0] r_mem [DEPTH];

    // ------------------------------------------------------------------
    // Write domain
    // ------------------------------------------------------------------
    logic [AW:0] r_wbin;
    logic [AW:0] r_wgray;
    logic [AW:0] r_rq_sync [SYNC_STAGES];
    logic        w_wpush;
    logic [AW:0] w_wbin_next;
    logic [AW:0] w_wgray_next;
    logic [AW:0] w_rgray_s;
    logic [AW:0] w_wlevel_next;
    logic        w_wfull_next;

    logic [AW:0] r_rbin;
    logic [AW:0] r_rgray;

    always_comb begin
        w_wpush       = winc & ~wfull;
        w_wbin_next   = r_wbin + {{AW{1'b0}}, w_wpush};
        w_wgray_next  = w_wbin_next ^ (w_wbin_next >> 1);
        w_rgray_s     = r_rq_sync[SYNC_STAGES-1];
        w_wlevel_next = w_wbin_next - gray2bin(w_rgray_s);
        // Full when the write pointer is exactly one lap ahead of the read pointer
        w_wfull_next  = (w_wgray_next == {~w_rgray_s[AW:AW-1], w_rgray_s[AW-2:0]});
    end

    always_ff @(posedge wclk or negedge wrstn) begin
        if (!wrstn) begin
            r_wbin       <= '0;
            r_wgray      <= '0;
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
            woverflow    <= 1'b0;
            wlevel       <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_rq_sync[i] <= '0;
            end
        end else begin
            r_wbin       <= w_wbin_next;
            r_wgray      <= w_wgray_next;
            wfull        <= w_wfull_next;
            walmost_full <= (w_wlevel_next >= c_af_lvl);
            woverflow    <= winc & wfull;
            wlevel       <= w_wlevel_next;
            r_rq_sync[0] <= r_rgray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_rq_sync[i] <= r_rq_sync[i-1];
            end
        end
    end

    always_ff @(posedge wclk) begin
        if (w_wpush) begin
            r_mem[r_wbin[AW-1:0]] <= wdata;
        end
    end

    // ------------------------------------------------------------------
    // Read domain
    // ------------------------------------------------------------------
    logic [AW:0] r_wq_sync [SYNC_STAGES];
    logic        w_rpop;
    logic [AW:0] w_rbin_next;
    logic [AW:0] w_rgray_next;
    logic [AW:0] w_wgray_s;
    logic [AW:0] w_rlevel_next;

    always_comb begin
        w_rpop        = rinc & ~rempty;
        w_rbin_next   = r_rbin + {{AW{1'b0}}, w_rpop};
        w_rgray_next  = w_rbin_next ^ (w_rbin_next >> 1);
        w_wgray_s     = r_wq_sync[SYNC_STAGES-1];
        w_rlevel_next = gray2bin(w_wgray_s) - w_rbin_next;
    end

    always_ff @(posedge rclk or negedge rrstn) begin
        if (!rrstn) begin
            r_rbin        <= '0;
            r_rgray       <= '0;
            rempty        <= 1'b1;
            ralmost_empty <= 1'b1;
            runderflow    <= 1'b0;
            rlevel        <= '0;
            rdata         <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_wq_sync[i] <= '0;
            end
        end else begin
            r_rbin        <= w_rbin_next;
            r_rgray       <= w_rgray_next;
            rempty        <= (w_rgray_next == w_wgray_s);
            ralmost_empty <= (w_rlevel_next <= c_ae_lvl);
            runderflow    <= rinc & rempty;
            rlevel        <= w_rlevel_next;
            if (w_rpop) begin
                rdata <= r_mem[r_rbin[AW-1:0]];
            end
            r_wq_sync[0] <= r_wgray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_wq_sync[i] <= r_wq_sync[i-1];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_async_fifo_lvl.sv
`default_nettype none
`timescale 1ns/100ps
// ============================================================================
// Module  : tb_async_fifo_lvl
// Brief   : Self-checking bench for async_fifo_lvl (vector table + scoreboard).
// Revision: 1.0 - initial release
// ============================================================================
module tb_async_fifo_lvl;

    logic       wclk = 1'b0;
    logic       rclk = 1'b0;
    logic       wrstn = 1'b1;
    logic       rrstn = 1'b1;
    logic       winc = 1'b0;
    logic       rinc = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic       wfull, walmost_full, woverflow;
    logic [4:0] wlevel;
    logic [7:0] rdata;
    logic       rempty, ralmost_empty, runderflow;
    logic [4:0] rlevel;

    async_fifo_lvl #(
        .WIDTH(8), .DEPTH(16), .SYNC_STAGES(2), .AF_LEVEL(14), .AE_LEVEL(2)
    ) dut (
        .wclk(wclk), .wrstn(wrstn), .winc(winc), .wdata(wdata),
        .wfull(wfull), .walmost_full(walmost_full), .woverflow(woverflow),
        .wlevel(wlevel),
        .rclk(rclk), .rrstn(rrstn), .rinc(rinc), .rdata(rdata),
        .rempty(rempty), .ralmost_empty(ralmost_empty), .runderflow(runderflow),
        .rlevel(rlevel)
    );

    always #5    wclk = ~wclk;
    always #13.5 rclk = ~rclk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] q[$];
    logic [7:0] last_rd = 8'h00;
    int         sent = 0;
    logic       ovf_seen = 1'b0;
    logic       unf_seen = 1'b0;
    logic       lvl_bad = 1'b0;

    typedef struct {
        logic       winc;
        logic [7:0] wdata;
        logic       exp_full;
        logic       exp_afull;
        logic       exp_ovf;
        logic [4:0] exp_lvl;
    } wvec_t;
    wvec_t vt[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pop_chk(input string name);
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL %s: got %0h expected none (scoreboard empty)", name, rdata);
        end else begin
            last_rd = q.pop_front();
            if (rdata !== last_rd) begin
                errors++;
                $display("FAIL %s: got %0h expected %0h", name, rdata, last_rd);
            end
        end
    endtask

    task automatic reset_chk(input string tag);
        chk({tag, "_wfull"},         wfull, 0);
        chk({tag, "_walmost_full"},  walmost_full, 0);
        chk({tag, "_woverflow"},     woverflow, 0);
        chk({tag, "_wlevel"},        wlevel, 0);
        chk({tag, "_rempty"},        rempty, 1);
        chk({tag, "_ralmost_empty"}, ralmost_empty, 1);
        chk({tag, "_runderflow"},    runderflow, 0);
        chk({tag, "_rlevel"},        rlevel, 0);
        chk({tag, "_rdata"},         rdata, 0);
    endtask

    task automatic do_reset(input string tag);
        wrstn = 1'b0;
        rrstn = 1'b0;
        #2;
        reset_chk(tag);
        repeat (3) @(negedge rclk);
        @(negedge wclk) wrstn = 1'b1;
        @(negedge rclk) rrstn = 1'b1;
        repeat (2) @(negedge rclk);
    endtask

    task automatic wr_word(input logic [7:0] d);
        @(negedge wclk);
        winc  = 1'b1;
        wdata = d;
        q.push_back(d);
        @(negedge wclk);
        winc = 1'b0;
    endtask

    task automatic rd_word(input string name);
        @(negedge rclk);
        rinc = 1'b1;
        @(negedge rclk);
        rinc = 1'b0;
        pop_chk(name);
    endtask

    task automatic wait_nonempty(input string name);
        int n = 0;
        while (rempty && n < 8) begin
            @(negedge rclk);
            n++;
        end
        chk(name, rempty, 0);
    endtask

    task automatic rand_writer();
        for (int cyc = 0; cyc < 20000 && sent < 200; cyc++) begin
            @(negedge wclk);
            if (woverflow) ovf_seen = 1'b1;
            if (wlevel > 5'd16) lvl_bad = 1'b1;
            if (!wfull && $urandom_range(0, 1) == 1) begin
                winc  = 1'b1;
                wdata = 8'($urandom);
                q.push_back(wdata);
                sent++;
            end else begin
                winc = 1'b0;
            end
        end
        @(negedge wclk);
        winc = 1'b0;
        chk("rand_sent", sent, 200);
    endtask

    task automatic rand_reader();
        int   got = 0;
        int   issued = 0;
        logic pend = 1'b0;
        for (int cyc = 0; cyc < 20000 && got < 200; cyc++) begin
            @(negedge rclk);
            if (runderflow) unf_seen = 1'b1;
            if (rlevel > 5'd16) lvl_bad = 1'b1;
            if (pend) begin
                pop_chk("rand_data");
                got++;
            end
            pend = 1'b0;
            if (issued < 200 && !rempty && $urandom_range(0, 2) != 0) begin
                rinc = 1'b1;
                pend = 1'b1;
                issued++;
            end else begin
                rinc = 1'b0;
            end
        end
        rinc = 1'b0;
        chk("rand_got", got, 200);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion (errors %0d)", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1;
        do_reset("rst0");

        // Single word into empty FIFO: release latency and level
        @(negedge wclk);
        winc  = 1'b1;
        wdata = 8'h3C;
        q.push_back(8'h3C);
        @(posedge wclk);
        #1;
        winc = 1'b0;
        chk("empty_before_sync", rempty, 1);
        chk("wlevel_one", wlevel, 1);
        for (int n = 0; n < 3 && rempty; n++) begin
            @(posedge rclk);
            #1;
        end
        chk("empty_release", rempty, 0);
        chk("rlevel_one", rlevel, 1);
        chk("ralmost_empty_one", ralmost_empty, 1);
        rd_word("single_rd");
        chk("single_rd_empty", rempty, 1);
        chk("single_rd_rlevel", rlevel, 0);
        repeat (10) @(negedge rclk);
        chk("single_wlevel_back", wlevel, 0);

        // Fill 16 words plus one overflow attempt
        for (int i = 0; i < 18; i++) begin
            int k;
            k = (i + 1 > 16) ? 16 : i + 1;
            vt[i].winc      = (i < 17);
            vt[i].wdata     = 8'(i);
            vt[i].exp_lvl   = 5'(k);
            vt[i].exp_afull = (k >= 14);
            vt[i].exp_full  = (k == 16);
            vt[i].exp_ovf   = (i == 16);
        end
        @(negedge wclk);
        for (int i = 0; i < 18; i++) begin
            winc  = vt[i].winc;
            wdata = vt[i].wdata;
            if (i < 16) q.push_back(vt[i].wdata);
            @(negedge wclk);
            chk($sformatf("fill%0d_wfull", i), wfull, vt[i].exp_full);
            chk($sformatf("fill%0d_afull", i), walmost_full, vt[i].exp_afull);
            chk($sformatf("fill%0d_ovf", i),   woverflow, vt[i].exp_ovf);
            chk($sformatf("fill%0d_wlevel", i), wlevel, vt[i].exp_lvl);
        end
        winc = 1'b0;

        // Drain all 16, then one underflow attempt
        repeat (5) @(negedge rclk);
        chk("rlevel_full", rlevel, 16);
        chk("ralmost_empty_full", ralmost_empty, 0);
        for (int i = 0; i < 16; i++) begin
            rinc = 1'b1;
            @(negedge rclk);
            pop_chk($sformatf("drain%0d", i));
        end
        chk("drain_empty", rempty, 1);
        @(negedge rclk);
        chk("underflow_pulse", runderflow, 1);
        chk("underflow_rdata", rdata, last_rd);
        rinc = 1'b0;
        @(negedge rclk);
        chk("underflow_clear", runderflow, 0);
        chk("drain_sb", q.size(), 0);

        // Random traffic with pointer wrap
        fork
            rand_writer();
            rand_reader();
        join
        repeat (10) @(negedge rclk);
        chk("rand_empty", rempty, 1);
        chk("rand_wlevel", wlevel, 0);
        chk("rand_ovf", ovf_seen, 0);
        chk("rand_unf", unf_seen, 0);
        chk("rand_lvl", lvl_bad, 0);
        chk("rand_sb", q.size(), 0);

        // Flush with data stored
        for (int i = 0; i < 5; i++) wr_word(8'(8'h50 + i));
        repeat (5) @(negedge rclk);
        chk("pre_flush_rlevel", rlevel, 5);
        do_reset("flush");
        q.delete();
        wr_word(8'hA5);
        wait_nonempty("flush_release");
        rd_word("flush_rd");
        chk("flush_rd_empty", rempty, 1);
        rinc = 1'b1;
        @(negedge rclk);
        rinc = 1'b0;
        chk("flush_underflow", runderflow, 1);
        chk("flush_rdata_hold", rdata, 8'hA5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
